// File: rtl/tx_crc_a_append.sv
// ISO/IEC 14443-3A transmit framer: byte stream in, LSbit-first bit stream out, CRC_A appended on request.
// Optional build macro: TX_CRC_A_RESIDUE_EN (fold appended CRC bits back into crc, leaving a zero residue).
module tx_crc_a_append (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  input  logic        in_append_crc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_data,
  output logic        out_last,
  output logic [15:0] crc
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DATA, S_CRC} state_t;

  state_t      state, state_n;
  logic [15:0] shift, shift_n;
  logic [15:0] crc_n, crc_upd;
  logic [3:0]  cnt, cnt_n;
  logic        last_q, last_n, app_q, app_n;
  logic        out_valid_n, out_last_n;

  // Reflected CRC_A: one bit of x^16+x^12+x^5+1, LSbit first.
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    return (c >> 1) ^ ((c[0] ^ b) ? 16'h8408 : 16'h0000);
  endfunction

  assign in_ready = (state == S_IDLE) || (state == S_WAIT);
  assign out_data = shift[0];
  assign crc_upd  = crc_step(crc, shift[0]);

  always_comb begin
    state_n = state;
    shift_n = shift;
    crc_n   = crc;
    cnt_n   = cnt;
    last_n  = last_q;
    app_n   = app_q;
    case (state)
      S_IDLE, S_WAIT: begin
        if (in_valid) begin
          state_n = S_DATA;
          shift_n = {8'h00, in_data};
          cnt_n   = 4'd0;
          last_n  = in_last;
          app_n   = in_append_crc;
          if (state == S_IDLE) crc_n = 16'h6363;
        end
      end
      S_DATA: begin
        if (out_ready) begin
          crc_n   = crc_upd;
          shift_n = shift >> 1;
          cnt_n   = cnt + 4'd1;
          if (cnt == 4'd7) begin
            cnt_n = 4'd0;
            if (!last_q)     state_n = S_WAIT;
            else if (!app_q) state_n = S_IDLE;
            else begin
              // CRC must include the final data bit shifted this cycle.
              state_n = S_CRC;
              shift_n = crc_upd;
            end
          end
        end
      end
      S_CRC: begin
        if (out_ready) begin
          shift_n = shift >> 1;
          cnt_n   = cnt + 4'd1;
`ifdef TX_CRC_A_RESIDUE_EN
          crc_n   = crc_upd;
`else
          crc_n   = crc;
`endif
          if (cnt == 4'd15) begin
            cnt_n   = 4'd0;
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
    out_valid_n = (state_n == S_DATA) || (state_n == S_CRC);
    out_last_n  = ((state_n == S_DATA) && (cnt_n == 4'd7) && last_n && !app_n) ||
                  ((state_n == S_CRC) && (cnt_n == 4'd15));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      shift     <= 16'h0000;
      crc       <= 16'h6363;
      cnt       <= 4'd0;
      last_q    <= 1'b0;
      app_q     <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      state     <= state_n;
      shift     <= shift_n;
      crc       <= crc_n;
      cnt       <= cnt_n;
      last_q    <= last_n;
      app_q     <= app_n;
      out_valid <= out_valid_n;
      out_last  <= out_last_n;
    end
  end

endmodule

// File: tb/tb_tx_crc_a_append.sv
// Bench for tx_crc_a_append: directed frames plus random frames against a bytewise CRC_A model.
module tb_tx_crc_a_append;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_last, in_append_crc;
  logic [7:0]  in_data;
  logic        out_valid, out_ready, out_data, out_last;
  logic [15:0] crc;

  int checks = 0;
  int failures = 0;
  logic [7:0] frm [$];

`ifdef TX_CRC_A_RESIDUE_EN
  localparam bit RES = 1'b1;
`else
  localparam bit RES = 1'b0;
`endif

  tx_crc_a_append dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_append_crc(in_append_crc),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .crc(crc)
  );

  always #5 clk = ~clk;

  // ISO/IEC 14443-3 reference byte-at-a-time CRC_A update.
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [7:0] ch;
    ch = b ^ c[7:0];
    ch = ch ^ (ch << 4);
    return (c >> 8) ^ {ch, 8'h00} ^ ({8'h00, ch} << 3) ^ ({8'h00, ch} >> 4);
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Sends frm; stall_pct = random out_ready low percentage, gap_max = idle cycles
  // between bytes, hold_at = transfer count after which out_ready drops for 5 cycles,
  // abort_at = transfer count at which to return early (caller then resets).
  task automatic run_frame(input bit app, input int stall_pct, input int gap_max,
                           input int hold_at, input int abort_at);
    bit          expq [$];
    logic [15:0] c;
    logic [15:0] exp_crc;
    int n, total, bi, gap, k, cyc, hold;
    bit prev_stall, prev_d, prev_l, xfer, acc, rdy;
    c = 16'h6363;
    foreach (frm[b]) begin
      for (int i = 0; i < 8; i++) expq.push_back(frm[b][i]);
      c = crc_byte(c, frm[b]);
    end
    if (app) for (int i = 0; i < 16; i++) expq.push_back(c[i]);
    exp_crc = (RES && app) ? 16'h0000 : c;
    n = frm.size(); total = expq.size();
    bi = 0; gap = 0; k = 0; cyc = 0; hold = 0; prev_stall = 0; prev_d = 0; prev_l = 0;
    while (k < total && cyc < 3000) begin
      if (bi < n && gap == 0) begin
        in_valid      = 1'b1;
        in_data       = frm[bi];
        in_last       = (bi == n - 1);
        in_append_crc = (bi == n - 1) ? app : frm[bi][0];
      end else begin
        in_valid = 1'b0;
      end
      out_ready = (hold > 0) ? 1'b0 :
                  ((stall_pct > 0 && $urandom_range(99) < stall_pct) ? 1'b0 : 1'b1);
      @(negedge clk);
      if (prev_stall) begin
        chk("hold_data", {15'd0, out_data}, {15'd0, prev_d});
        chk("hold_last", {15'd0, out_last}, {15'd0, prev_l});
      end
      if (in_ready) chk("idle_valid", {15'd0, out_valid}, 16'd0);
      xfer = out_valid && out_ready;
      acc  = in_valid && in_ready;
      rdy  = in_ready;
      if (xfer) begin
        chk("bit", {15'd0, out_data}, {15'd0, expq[k]});
        chk("last", {15'd0, out_last}, {15'd0, (k == total - 1)});
      end
      prev_stall = out_valid && !out_ready;
      prev_d = out_data; prev_l = out_last;
      @(posedge clk); #1;
      if (acc) begin
        bi++;
        gap = (gap_max > 0) ? $urandom_range(gap_max) : 0;
      end else if (gap > 0 && rdy) gap--;
      if (hold > 0) hold--;
      if (xfer) begin
        k++;
        if (k == hold_at) hold = 5;
      end
      cyc++;
      if (abort_at >= 0 && k == abort_at) break;
    end
    in_valid = 1'b0;
    checks++;
    assert (cyc < 3000) else begin
      failures++;
      $error("FAIL timeout: got %0d bits expected %0d", k, total);
    end
    if (abort_at < 0 || k != abort_at) begin
      chk("end_valid", {15'd0, out_valid}, 16'd0);
      chk("end_ready", {15'd0, in_ready}, 16'd1);
      chk("end_crc", crc, exp_crc);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; in_data = 0; in_last = 0; in_append_crc = 0; out_ready = 0;
    #12;
    chk("rst_ready", {15'd0, in_ready}, 16'd1);
    chk("rst_valid", {15'd0, out_valid}, 16'd0);
    chk("rst_data", {15'd0, out_data}, 16'd0);
    chk("rst_last", {15'd0, out_last}, 16'd0);
    chk("rst_crc", crc, 16'h6363);
    #3 rst = 1'b0;
    @(posedge clk); #1;

    frm = {8'h00, 8'h00};
    run_frame(1'b1, 0, 0, -1, -1);
    chk("crc_0000", crc, RES ? 16'h0000 : 16'h1EA0);

    frm = {8'h12, 8'h34};
    run_frame(1'b1, 0, 5, -1, -1);
    chk("crc_1234", crc, RES ? 16'h0000 : 16'hCF26);

    frm = {8'hA5};
    run_frame(1'b0, 0, 0, 3, -1);

    // Reset while CRC bit 7 is on the output.
    frm = {8'h00, 8'h00};
    run_frame(1'b1, 0, 0, -1, 23);
    rst = 1'b1;
    #1;
    chk("arst_valid", {15'd0, out_valid}, 16'd0);
    chk("arst_ready", {15'd0, in_ready}, 16'd1);
    chk("arst_crc", crc, 16'h6363);
    chk("arst_last", {15'd0, out_last}, 16'd0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    run_frame(1'b1, 0, 0, -1, -1);
    chk("crc_after_rst", crc, RES ? 16'h0000 : 16'h1EA0);

    // Back-to-back: next frame offered right in the cycle after the final transfer.
    frm = {8'h5A, 8'hC3, 8'h01};
    run_frame(1'b0, 0, 0, -1, -1);
    frm = {8'h00, 8'h00};
    run_frame(1'b1, 0, 0, -1, -1);
    chk("crc_b2b", crc, RES ? 16'h0000 : 16'h1EA0);

    for (int f = 0; f < 1000; f++) begin
      int len;
      len = $urandom_range(10, 1);
      frm = {};
      for (int i = 0; i < len; i++) frm.push_back(8'($urandom));
      run_frame(1'($urandom), 10, 1, -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
